// File: rtl/jpu_pkg.sv
// Shared JPU datapath constants, sequencer state encoding and request bundle.
// Imported by the register-file access controller and the register file.
package jpu_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        CAPT = 3'd2,
        OPND = 3'd3,
        WAIT = 3'd4,
        WB   = 3'd5
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [ADDR_W-1:0] rs1;
        logic [ADDR_W-1:0] rs2;
        logic              no_read;
        logic              no_wb;
        logic [DATA_W-1:0] imm;
    } req_t;

endpackage

// File: rtl/jpu_regfile.sv
// 8x16 register file: registered two-port read, single write port.
// Enable with neither strobe clears the read outputs.
module jpu_regfile
    import jpu_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              enable_read,
    input  logic              enable_write,
    input  logic [ADDR_W-1:0] addrA,
    input  logic [ADDR_W-1:0] addrB,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] dataA,
    output logic [DATA_W-1:0] dataB
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2**ADDR_W; i++) begin
                mem[i] <= '0;
            end
            dataA <= '0;
            dataB <= '0;
        end else if (enable) begin
            if (enable_write) begin
                mem[addrA] <= data_in;
            end
            if (enable_read) begin
                dataA <= mem[addrA];
                dataB <= mem[addrB];
            end else if (!enable_write) begin
                dataA <= '0;
                dataB <= '0;
            end
        end
    end

endmodule

// File: rtl/regfile_access_ctrl.sv
// Register-file sequencer: operand fetch, ALU handshake, write-back.
// One operation in flight at a time.
module regfile_access_ctrl
    import jpu_pkg::*;
#(
    parameter int DATA_W = jpu_pkg::DATA_W,
    parameter int ADDR_W = jpu_pkg::ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_rd,
    input  logic [ADDR_W-1:0] req_rs1,
    input  logic [ADDR_W-1:0] req_rs2,
    input  logic              req_no_read,
    input  logic              req_no_wb,
    input  logic [DATA_W-1:0] req_imm,
    output logic              rf_enable,
    output logic              rf_enable_read,
    output logic              rf_enable_write,
    output logic [ADDR_W-1:0] rf_addrA,
    output logic [ADDR_W-1:0] rf_addrB,
    output logic [DATA_W-1:0] rf_data_in,
    input  logic [DATA_W-1:0] rf_dataA,
    input  logic [DATA_W-1:0] rf_dataB,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              busy
);

    state_t            state;
    state_t            state_nx;
    req_t              req_q;
    logic [DATA_W-1:0] res_q;
    logic              accept;

    assign accept = (state == IDLE) && req_valid;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (req_valid) begin
                    state_nx = req_no_read ? OPND : READ;
                end
            end
            READ: state_nx = CAPT;
            CAPT: state_nx = OPND;
            OPND: begin
                if (op_ready) begin
                    state_nx = WAIT;
                end
            end
            WAIT: begin
                if (res_valid) begin
                    state_nx = req_q.no_wb ? IDLE : WB;
                end
            end
            WB:      state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operands are loaded either from the immediate on accept or
    // from the file's registered read port during CAPT.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_q <= '0;
            op_a  <= '0;
            op_b  <= '0;
            res_q <= '0;
        end else begin
            if (accept) begin
                req_q.rd      <= req_rd;
                req_q.rs1     <= req_rs1;
                req_q.rs2     <= req_rs2;
                req_q.no_read <= req_no_read;
                req_q.no_wb   <= req_no_wb;
                req_q.imm     <= req_imm;
                if (req_no_read) begin
                    op_a <= req_imm;
                    op_b <= req_imm;
                end
            end
            if (state == CAPT) begin
                op_a <= rf_dataA;
                op_b <= rf_dataB;
            end
            if ((state == WAIT) && res_valid) begin
                res_q <= res_data;
            end
        end
    end

    always_comb begin
        req_ready       = 1'b0;
        busy            = 1'b1;
        op_valid        = 1'b0;
        rf_enable       = 1'b0;
        rf_enable_read  = 1'b0;
        rf_enable_write = 1'b0;
        rf_addrA        = '0;
        rf_addrB        = '0;
        rf_data_in      = '0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
            end
            READ: begin
                rf_enable      = 1'b1;
                rf_enable_read = 1'b1;
                rf_addrA       = req_q.rs1;
                rf_addrB       = req_q.rs2;
            end
            OPND: op_valid = 1'b1;
            WB: begin
                rf_enable       = 1'b1;
                rf_enable_write = 1'b1;
                rf_addrA        = req_q.rd;
                rf_data_in      = res_q;
            end
            default: ;
        endcase
    end

endmodule
